// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulation controller: sequences operand accepts, psum clear/enable and result handoff.
// Optional stall counter is built only when PSUM_ACC_CTRL_STALL_CNT_EN is defined.
module psum_acc_ctrl #(
  parameter int CNT_WIDTH   = 4,
  parameter int STALL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   filt_len,
  input  logic [CNT_WIDTH-1:0]   num_psums,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   in_reg_en,
  output logic                   psum_en,
  output logic                   psum_clear,
  output logic                   psum_valid,
  input  logic                   psum_ready,
  output logic                   busy,
`ifdef PSUM_ACC_CTRL_STALL_CNT_EN
  output logic [STALL_WIDTH-1:0] stall_cnt,
`endif
  output logic                   done
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here after a run
  // CLEAR | one-cycle clear of the psum register
  // ACC   | accepting operand pairs until filt_len MACs
  // FLUSH | last accumulate lands (delayed psum_en)
  // OUT   | psum_valid held until psum_ready
  typedef enum logic [2:0] {IDLE, CLEAR, ACC, FLUSH, OUT} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] filt_len_q, num_psums_q;
  logic [CNT_WIDTH-1:0] mac_cnt, psum_cnt;
  logic [CNT_WIDTH-1:0] mac_inc, psum_inc;
  logic                 psum_en_q, done_q;
  logic                 accept, handshake, start_ok, start_bad, last_psum;

  assign mac_inc  = mac_cnt + CNT_WIDTH'(1);
  assign psum_inc = psum_cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    in_reg_en  = 1'b0;
    psum_clear = 1'b0;
    psum_valid = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    last_psum  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (filt_len != '0 && num_psums != '0) begin
            start_ok  = 1'b1;
            state_nxt = CLEAR;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      CLEAR: begin
        psum_clear = 1'b1;
        state_nxt  = ACC;
      end
      ACC: begin
        in_ready  = 1'b1;
        in_reg_en = in_valid;
        accept    = in_valid;
        if (accept && mac_inc == filt_len_q) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = OUT;
      OUT: begin
        psum_valid = 1'b1;
        if (psum_ready) begin
          handshake = 1'b1;
          last_psum = (psum_inc == num_psums_q);
          state_nxt = last_psum ? IDLE : CLEAR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration is captured only on an accepted start, so bus changes mid-run are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_len_q  <= '0;
      num_psums_q <= '0;
      mac_cnt     <= '0;
      psum_cnt    <= '0;
      psum_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      psum_en_q <= accept;
      done_q    <= start_bad | (handshake & last_psum);
      if (start_ok) begin
        filt_len_q  <= filt_len;
        num_psums_q <= num_psums;
        mac_cnt     <= '0;
        psum_cnt    <= '0;
      end else begin
        if (state == CLEAR) mac_cnt <= '0;
        else if (accept)    mac_cnt <= mac_inc;
        if (handshake)      psum_cnt <= psum_inc;
      end
    end
  end

`ifdef PSUM_ACC_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (((state == ACC && !in_valid) || (state == OUT && !psum_ready)) &&
                 stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_WIDTH'(1);
    end
  end
`endif

  assign psum_en = psum_en_q;
  assign busy    = (state != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl: directed scenarios plus randomized runs
// checked against run-level expectations (accept totals, pulse counts, latencies).
module tb_psum_acc_ctrl;

  localparam int CW = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, psum_ready;
  logic [CW-1:0] filt_len, num_psums;
  logic          in_ready, in_reg_en, psum_en, psum_clear, psum_valid, busy, done;
`ifdef PSUM_ACC_CTRL_STALL_CNT_EN
  logic [SW-1:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  psum_acc_ctrl #(.CNT_WIDTH(CW), .STALL_WIDTH(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filt_len   (filt_len),
    .num_psums  (num_psums),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg_en  (in_reg_en),
    .psum_en    (psum_en),
    .psum_clear (psum_clear),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .busy       (busy),
`ifdef PSUM_ACC_CTRL_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; psum_ready = 1'b1;
    filt_len = 4'd3; num_psums = 4'd1;
    step(); step();
    outs = {in_ready, in_reg_en, psum_en, psum_clear, psum_valid, busy, done};
    checks++;
    if (outs !== 7'b0) begin
      failures++; $display("FAIL reset_outputs: got %b expected %b", outs, 7'b0);
    end
`ifdef PSUM_ACC_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== '0) begin
      failures++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
    end
`endif
    rst = 1'b0; in_valid = 1'b0; psum_ready = 1'b0;
    step();
  endtask

  // filt_len=3, num_psums=1, start in cycle 0; bit i of each mask is cycle i+1.
  task automatic test_scenario_timing();
    logic [7:0] e_clr  = 8'b0000_0001;
    logic [7:0] e_rdy  = 8'b0000_1110;
    logic [7:0] e_en   = 8'b0001_1100;
    logic [7:0] e_val  = 8'b0010_0000;
    logic [7:0] e_done = 8'b0100_0000;
    logic [7:0] e_busy = 8'b0011_1111;
    logic [5:0] got, exp;
    filt_len = 4'd3; num_psums = 4'd1; in_valid = 1'b1; psum_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      start = 1'b0;
      got = {psum_clear, in_ready, psum_en, psum_valid, done, busy};
      exp = {e_clr[c], e_rdy[c], e_en[c], e_val[c], e_done[c], e_busy[c]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL timing_cycle%0d clr/rdy/en/val/done/busy: got %b expected %b", c + 1, got, exp);
      end
    end
    in_valid = 1'b0; psum_ready = 1'b0;
    step();
  endtask

  task automatic zero_case(input int f, input int n);
    logic [3:0] got;
    filt_len = CW'(f); num_psums = CW'(n); start = 1'b1;
    step();
    start = 1'b0;
    got = {done, busy, in_ready, psum_clear};
    checks++;
    if (got !== 4'b1000) begin
      failures++; $display("FAIL zero_cfg f=%0d n=%0d done/busy/rdy/clr: got %b expected 1000", f, n, got);
    end
    step();
    got = {done, busy, in_ready, psum_clear};
    checks++;
    if (got !== 4'b0000) begin
      failures++; $display("FAIL zero_cfg_after f=%0d n=%0d: got %b expected 0000", f, n, got);
    end
  endtask

  task automatic test_zero_config();
    zero_case(0, 2);
    zero_case(3, 0);
  endtask

  // One full run. rnd: random in_valid/psum_ready; noise: start/config toggling while busy;
  // otherwise in_valid gaps of 'gap' cycles after each accept and psum_ready low for 'rlow' OUT cycles.
  task automatic run_check(input int f, input int n, input bit rnd, input bit noise,
                           input int gap, input int rlow, input int exp_stall, input string nm);
    int acc_tot = 0, clr = 0, hs_tot = 0, en_tot = 0, done_cnt = 0, seg_acc = 0;
    int since = 99, gap_left = 0, wait_c = 0, stall_m = 0, cyc = 0;
    bit prev_acc = 0, prev_valid = 0, acc, hs;
    filt_len = CW'(f); num_psums = CW'(n); start = 1'b1; in_valid = 1'b0; psum_ready = 1'b0;
    step();
    start = 1'b0;
    while (cyc < 2000) begin
      checks++;
      if (psum_en !== prev_acc) begin
        failures++; $display("FAIL %s psum_en_latency cyc%0d: got %b expected %b", nm, cyc, psum_en, prev_acc);
      end
      checks++;
      if (psum_clear && psum_en) begin
        failures++; $display("FAIL %s clear_and_en cyc%0d: got 1 expected 0", nm, cyc);
      end
      if (psum_en) en_tot++;
      if (psum_clear) begin clr++; seg_acc = 0; end
      if (psum_valid && !prev_valid) begin
        checks++;
        if (since != 2) begin
          failures++; $display("FAIL %s valid_after_last_accept: got %0d expected 2", nm, since);
        end
        checks++;
        if (seg_acc != f) begin
          failures++; $display("FAIL %s accepts_per_psum: got %0d expected %0d", nm, seg_acc, f);
        end
      end
      if (done) begin done_cnt++; break; end
      in_valid   = rnd ? ($urandom_range(0, 3) != 0) : (gap_left == 0);
      psum_ready = rnd ? ($urandom_range(0, 2) != 0) : (wait_c >= rlow);
      if (noise) begin
        start     = $urandom_range(0, 1) != 0;
        filt_len  = CW'($urandom_range(0, 15));
        num_psums = CW'($urandom_range(0, 15));
      end
      acc = in_valid && in_ready;
      hs  = psum_valid && psum_ready;
      if ((in_ready && !in_valid) || (psum_valid && !psum_ready)) stall_m++;
      if (acc) begin acc_tot++; seg_acc++; since = 0; gap_left = gap; end
      else if (gap_left > 0) gap_left--;
      if (psum_valid) begin
        if (hs) begin hs_tot++; wait_c = 0; end
        else wait_c++;
      end
      prev_acc = acc; prev_valid = psum_valid;
      step();
      cyc++; since++;
    end
    start = 1'b0; in_valid = 1'b0; psum_ready = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      failures++; $display("FAIL %s done_count: got %0d expected 1 (cycles %0d)", nm, done_cnt, cyc);
    end
    checks++;
    if (acc_tot != f * n) begin
      failures++; $display("FAIL %s accepts: got %0d expected %0d", nm, acc_tot, f * n);
    end
    checks++;
    if (en_tot != f * n) begin
      failures++; $display("FAIL %s psum_en_count: got %0d expected %0d", nm, en_tot, f * n);
    end
    checks++;
    if (clr != n) begin
      failures++; $display("FAIL %s clear_count: got %0d expected %0d", nm, clr, n);
    end
    checks++;
    if (hs_tot != n) begin
      failures++; $display("FAIL %s handshakes: got %0d expected %0d", nm, hs_tot, n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL %s busy_at_done: got %b expected 0", nm, busy);
    end
`ifdef PSUM_ACC_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== SW'(stall_m)) begin
      failures++; $display("FAIL %s stall_model: got %0d expected %0d", nm, stall_cnt, stall_m);
    end
    if (exp_stall >= 0) begin
      checks++;
      if (stall_cnt !== SW'(exp_stall)) begin
        failures++; $display("FAIL %s stall_fixed: got %0d expected %0d", nm, stall_cnt, exp_stall);
      end
    end
`endif
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL %s done_width: got %b expected 0", nm, done);
    end
  endtask

  task automatic test_multi_psum();
    run_check(2, 3, 1'b0, 1'b0, 0, 0, -1, "multi_psum");
  endtask

  task automatic test_gaps();
    run_check(3, 1, 1'b0, 1'b0, 2, 4, 8, "gaps");
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] outs;
    filt_len = 4'd4; num_psums = 4'd1; in_valid = 1'b1; psum_ready = 1'b1; start = 1'b1;
    step();          // CLEAR
    start = 1'b0;
    step();          // ACC, first accept at next edge
    step();          // ACC, one accept done
    rst = 1'b1;
    step();
    outs = {in_ready, in_reg_en, psum_en, psum_clear, psum_valid, busy, done};
    checks++;
    if (outs !== 7'b0) begin
      failures++; $display("FAIL mid_reset_outputs: got %b expected %b", outs, 7'b0);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++; $display("FAIL mid_reset_idle cyc%0d busy/done: got %b expected 00", i, {busy, done});
      end
    end
    run_check(2, 2, 1'b0, 1'b0, 0, 1, -1, "after_reset");
  endtask

  task automatic test_ignore_start();
    run_check(3, 2, 1'b0, 1'b1, 0, 0, -1, "ignore_start");
  endtask

  task automatic test_back_to_back();
    run_check(1, 1, 1'b0, 1'b0, 0, 0, -1, "b2b_a");
    run_check(5, 2, 1'b0, 1'b0, 1, 2, -1, "b2b_b");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++)
      run_check($urandom_range(1, 6), $urandom_range(1, 4), 1'b1, 1'b1, 0, 0, -1, "random");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; psum_ready = 1'b0;
    filt_len = '0; num_psums = '0;
    test_reset();
    test_scenario_timing();
    test_zero_config();
    test_multi_psum();
    test_gaps();
    test_reset_mid_run();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_acc_ctrl.md
PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 4, the width of the MAC and psum counters and of the configuration inputs.
REQ-002 SHALL have parameter STALL_WIDTH, default 16, the width of the stall counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-006 SHALL have port filt_len, input, CNT_WIDTH bits: MACs per psum, latched on start.
REQ-007 SHALL have port num_psums, input, CNT_WIDTH bits: psums per run, latched on start.
REQ-008 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): operand-pair handshake.
REQ-009 SHALL have port in_reg_en, output, 1 bit: enable of the ifmap/filter operand registers.
REQ-010 SHALL have ports psum_en (output, 1 bit) and psum_clear (output, 1 bit): enable and clear of the psum register.
REQ-011 SHALL have ports psum_valid (output, 1 bit) and psum_ready (input, 1 bit): result handshake.
REQ-012 SHALL have ports busy (output, 1 bit) and done (output, 1 bit): busy is high outside IDLE; done is a 1-cycle end-of-run pulse.
REQ-013 SHALL have port stall_cnt, output, STALL_WIDTH bits; it is present only with the macro in REQ-028.

Function
REQ-014 SHALL implement the FSM states IDLE, CLEAR, ACC, FLUSH and OUT.
REQ-015 IDLE: on start with filt_len!=0 and num_psums!=0, SHALL latch both configuration values, zero both counters and go to CLEAR next cycle.
REQ-016 IDLE: on start with filt_len==0 or num_psums==0, SHALL pulse done the next cycle and stay in IDLE.
REQ-017 CLEAR: SHALL assert psum_clear for exactly 1 cycle, zero mac_cnt and go to ACC.
REQ-018 ACC: SHALL drive in_ready=1 and in_reg_en=in_valid; each accept (in_valid&in_ready) SHALL increment mac_cnt.
REQ-019 psum_en SHALL be the accept signal delayed by one registered cycle, giving a fixed 1-cycle operand-to-accumulate latency.
REQ-020 ACC: on the accept that brings mac_cnt to filt_len, SHALL go to FLUSH; in_ready SHALL be 0 outside ACC.
REQ-021 FLUSH: SHALL last exactly 1 cycle (the last psum_en occurs here) and then go to OUT.
REQ-022 OUT: SHALL hold psum_valid=1 until psum_ready, then increment psum_cnt.
REQ-023 OUT: after the handshake, if psum_cnt reaches num_psums, SHALL go to IDLE with done pulsed in the first IDLE cycle; otherwise SHALL go to CLEAR.
REQ-024 start SHALL be ignored while busy=1, and configuration changes while busy SHALL have no effect.
REQ-025 psum_clear and psum_en SHALL never be asserted in the same cycle.

Reset
REQ-026 While rst=1 at a clock edge, SHALL force the FSM to IDLE and zero both counters, the psum_en pipeline register and stall_cnt.
REQ-027 Outputs after reset: in_ready, in_reg_en, psum_en, psum_clear, psum_valid, busy and done SHALL all be 0; reset mid-run SHALL abort with no done pulse.

Configuration
REQ-028 With macro PSUM_ACC_CTRL_STALL_CNT_EN defined, stall_cnt SHALL count cycles in ACC with in_valid=0 plus cycles in OUT with psum_ready=0.
REQ-029 With the macro defined, stall_cnt SHALL clear on an accepted start and saturate at all-ones; without the macro, the port and its logic SHALL be absent.

Verification
REQ-030 Scenario: filt_len=3, num_psums=1, in_valid constantly 1, start at cycle 0, psum_ready=1 -> psum_clear at cycle 1; accepts at cycles 2-4; psum_en at cycles 3-5; psum_valid at cycle 6; done at cycle 7.
REQ-031 Scenario: filt_len=2, num_psums=3 -> exactly 3 psum_valid handshakes, 3 psum_clear pulses and 6 accepts; done once.
REQ-032 Scenario: start with filt_len=0 -> done pulse the next cycle; busy, in_ready and psum_clear stay 0.
REQ-033 Scenario: in_valid gaps of 2 cycles between operands and psum_ready held low 4 cycles in OUT -> mac_cnt holds during gaps; psum_valid stays high; with the macro, stall_cnt=8 for filt_len=3 (2 gaps x2 plus 4).
REQ-034 Scenario: rst=1 asserted in ACC after 1 accept -> next cycle all outputs 0, state IDLE, no done; a new start runs normally.
REQ-035 Scenario: start pulsed while busy with different filt_len -> ignored; the current run completes with the original length.
